// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the shared-decoder arbiter.
// The arbiter consumes requests and addresses and produces the grant, the
// completion pulse and the decoder drive signals.
interface decoder_rr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5
);
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [ADDR_W-1:0]      dec_din;
    logic                   dec_en;
    logic                   busy;

    // Requester side: raises requests and watches grant/done.
    modport master (
        output req,
        output addr,
        input  gnt,
        input  done,
        input  dec_din,
        input  dec_en,
        input  busy
    );

    // Arbiter side: samples requests and drives grant and decoder controls.
    modport slave (
        input  req,
        input  addr,
        output gnt,
        output done,
        output dec_din,
        output dec_en,
        output busy
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one enabled 5-to-32 decoder among NREQ
// requesters. A grant drives the decoder select/enable for HOLD cycles,
// then pulses done to the winner for one cycle before returning to IDLE.
module decoder_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int HOLD   = 2
) (
    input  logic                clk,
    input  logic                rst,
    decoder_rr_arbiter_if.slave bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [PTR_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_holdCnt;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_done;
    logic [ADDR_W-1:0]   r_decDin;
    logic                r_decEn;

    logic                w_anyReq;
    logic [PTR_W-1:0]    w_winner;
    logic [PTR_W-1:0]    w_ptrNext;
    logic [NREQ-1:0]     w_grantVec;
    logic [ADDR_W-1:0]   w_addrSel;
    logic                w_holdDone;

    // Scan from ptr upward, wrapping modulo NREQ; the first set request wins.
    function automatic logic [PTR_W-1:0] rrPick(
        input logic [NREQ-1:0]  req,
        input logic [PTR_W-1:0] ptr
    );
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                pick  = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Winner selection and everything derived from it for the grant edge.
    always_comb begin
        w_anyReq   = |bus.req;
        w_winner   = rrPick(bus.req, r_ptr);
        w_ptrNext  = (w_winner == PTR_W'(NREQ - 1)) ? '0 : w_winner + PTR_W'(1);
        w_grantVec = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
        w_addrSel  = bus.addr[int'(w_winner)*ADDR_W +: ADDR_W];
        w_holdDone = (r_holdCnt == CNT_W'(HOLD));
    end

    // State register; reset always returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: grant on any request, hold for HOLD cycles, release for one.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = DRIVE;
                end
            end
            DRIVE: begin
                if (w_holdDone) begin
                    w_nextState = RELEASE;
                end
            end
            RELEASE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Grant, decoder drive, completion pulse, pointer and hold counter.
    // The counter starts at 1 on the grant edge so DRIVE ends when it reaches HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_holdCnt <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_decDin  <= '0;
            r_decEn   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_gnt     <= w_grantVec;
                        r_decDin  <= w_addrSel;
                        r_decEn   <= 1'b1;
                        r_ptr     <= w_ptrNext;
                        r_holdCnt <= CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (w_holdDone) begin
                        r_decEn   <= 1'b0;
                        r_done    <= r_gnt;
                        r_holdCnt <= '0;
                    end else begin
                        r_holdCnt <= r_holdCnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    r_gnt  <= '0;
                    r_done <= '0;
                end
                default: begin
                    r_gnt   <= '0;
                    r_done  <= '0;
                    r_decEn <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.dec_din = r_decDin;
    assign bus.dec_en  = r_decEn;
    assign bus.busy    = (r_state != IDLE);

endmodule
